// File: rtl/cdb_result_queue.sv
// In-order result buffer at the completion end of a functional unit.
// Requests the CDB and, on a registered grant, presents the head result in that same cycle.
module cdb_result_queue #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push_valid,
  input  logic [TAG_W-1:0]           push_tag,
  input  logic [DATA_W-1:0]          push_data,
  output logic                       push_ready,
  output logic                       cdb_request,
  input  logic                       cdb_grant,
  output logic                       out_valid,
  output logic [TAG_W-1:0]           out_tag,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count_dbg
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [TAG_W-1:0]  tag_mem_r  [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [PW-1:0]     head_r;
  logic [PW-1:0]     tail_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_next_s;
  logic              push_s;
  logic              pop_s;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign push_ready = (count_r < DEPTH_C) && !reset;
  assign push_s     = push_valid && push_ready && !flush;
  assign pop_s      = cdb_grant && (count_r != {CW{1'b0}}) && !flush && !reset;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Request reflects the grant in flight so a drained queue stops asking at once.
  assign cdb_request = (count_next_s != {CW{1'b0}}) && !flush && !reset;
  assign out_valid   = pop_s;
  assign out_tag     = pop_s ? tag_mem_r[head_r]  : {TAG_W{1'b0}};
  assign out_data    = pop_s ? data_mem_r[head_r] : {DATA_W{1'b0}};
  assign count_dbg   = count_r;

  // Pointer and occupancy state; flush empties the queue like reset.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= next_ptr(tail_r);
      end
      if (pop_s) begin
        head_r <= next_ptr(head_r);
      end
      count_r <= count_next_s;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push_s) begin
      tag_mem_r[tail_r]  <= push_tag;
      data_mem_r[tail_r] <= push_data;
    end
  end

  cdb_result_queue_checker #(.CW(CW)) u_chk (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .cdb_grant  (cdb_grant),
    .count      (count_r)
  );

endmodule

// Protocol checker: flags dropped pushes and grants that arrive with nothing queued.
module cdb_result_queue_checker #(
  parameter int CW = 3
) (
  input logic          clock,
  input logic          reset,
  input logic          flush,
  input logic          push_valid,
  input logic          push_ready,
  input logic          cdb_grant,
  input logic [CW-1:0] count
);

  logic [15:0] viol_cnt_r;

  // Count and report protocol violations outside reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      viol_cnt_r <= 16'd0;
    end else begin
      assert (!(push_valid && !push_ready))
      else $warning("cdb_result_queue: push while queue full, result dropped");
      assert (!(cdb_grant && !flush && (count == {CW{1'b0}})))
      else $warning("cdb_result_queue: grant received with empty queue");
      if ((push_valid && !push_ready) || (cdb_grant && !flush && (count == {CW{1'b0}}))) begin
        viol_cnt_r <= viol_cnt_r + 16'd1;
      end else begin
        viol_cnt_r <= viol_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_cdb_result_queue.sv
// Directed bench for cdb_result_queue with DEPTH=4, TAG_W=6, DATA_W=32.
// Inputs change just after the rising edge; outputs are sampled on the falling edge.
module tb_cdb_result_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        push_valid = 1'b0;
  logic [5:0]  push_tag = 6'd0;
  logic [31:0] push_data = 32'd0;
  logic        push_ready;
  logic        cdb_request;
  logic        cdb_grant = 1'b0;
  logic        out_valid;
  logic [5:0]  out_tag;
  logic [31:0] out_data;
  logic [2:0]  count_dbg;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  cdb_result_queue #(.DEPTH(4), .TAG_W(6), .DATA_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .push_valid  (push_valid),
    .push_tag    (push_tag),
    .push_data   (push_data),
    .push_ready  (push_ready),
    .cdb_request (cdb_request),
    .cdb_grant   (cdb_grant),
    .out_valid   (out_valid),
    .out_tag     (out_tag),
    .out_data    (out_data),
    .count_dbg   (count_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle's inputs and move to the sampling point of that cycle.
  task automatic drive(input logic pv, input logic [5:0] tg, input logic [31:0] dt,
                       input logic gr, input logic fl);
    push_valid = pv;
    push_tag   = tg;
    push_data  = dt;
    cdb_grant  = gr;
    flush      = fl;
    @(negedge clock);
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset: pushes and grants ignored, outputs quiet.
    reset = 1'b1;
    drive(1'b1, 6'd33, 32'h1234, 1'b1, 1'b0);
    chk("rst_req", 32'(cdb_request), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_prdy", 32'(push_ready), 32'd0);
    chk("rst_otag", 32'(out_tag), 32'd0);
    nxt();
    reset = 1'b0;
    drive(1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
    chk("post_rst_prdy", 32'(push_ready), 32'd1);
    chk("post_rst_cnt", 32'(count_dbg), 32'd0);
    chk("post_rst_req", 32'(cdb_request), 32'd0);
    nxt();

    // Single push, granted next cycle.
    drive(1'b1, 6'd5, 32'hDEAD, 1'b0, 1'b0);
    chk("t1_req0", 32'(cdb_request), 32'd1);
    chk("t1_ov0", 32'(out_valid), 32'd0);
    nxt();
    drive(1'b0, 6'd0, 32'd0, 1'b1, 1'b0);
    chk("t1_ov1", 32'(out_valid), 32'd1);
    chk("t1_tag1", 32'(out_tag), 32'd5);
    chk("t1_data1", out_data, 32'hDEAD);
    chk("t1_req1", 32'(cdb_request), 32'd0);
    nxt();
    drive(1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
    chk("t1_cnt2", 32'(count_dbg), 32'd0);
    nxt();

    // Streaming tags 1,2,3 with back-to-back grants.
    drive(1'b1, 6'd1, 32'h11, 1'b0, 1'b0);
    chk("t2_req0", 32'(cdb_request), 32'd1);
    nxt();
    drive(1'b1, 6'd2, 32'h22, 1'b1, 1'b0);
    chk("t2_tag1", 32'(out_tag), 32'd1);
    chk("t2_req1", 32'(cdb_request), 32'd1);
    nxt();
    drive(1'b1, 6'd3, 32'h33, 1'b1, 1'b0);
    chk("t2_tag2", 32'(out_tag), 32'd2);
    chk("t2_data2", out_data, 32'h22);
    chk("t2_req2", 32'(cdb_request), 32'd1);
    nxt();
    drive(1'b0, 6'd0, 32'd0, 1'b1, 1'b0);
    chk("t2_tag3", 32'(out_tag), 32'd3);
    chk("t2_ov3", 32'(out_valid), 32'd1);
    chk("t2_req3", 32'(cdb_request), 32'd0);
    nxt();
    drive(1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
    chk("t2_cnt4", 32'(count_dbg), 32'd0);
    nxt();

    // Denied request is held until granted.
    drive(1'b1, 6'd9, 32'h99, 1'b0, 1'b0);
    chk("t3_req0", 32'(cdb_request), 32'd1);
    nxt();
    for (int c = 1; c <= 3; c++) begin
      drive(1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
      chk("t3_wait_req", 32'(cdb_request), 32'd1);
      chk("t3_wait_ov", 32'(out_valid), 32'd0);
      chk("t3_wait_cnt", 32'(count_dbg), 32'd1);
      nxt();
    end
    drive(1'b0, 6'd0, 32'd0, 1'b1, 1'b0);
    chk("t3_ov4", 32'(out_valid), 32'd1);
    chk("t3_tag4", 32'(out_tag), 32'd9);
    nxt();

    // Fill to DEPTH, drop a fifth push, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'(10 + i), 32'(16'hA000 + i), 1'b0, 1'b0);
      chk("t4_fill_prdy", 32'(push_ready), 32'd1);
      nxt();
    end
    drive(1'b1, 6'd14, 32'hA004, 1'b0, 1'b0);
    chk("t4_full_prdy", 32'(push_ready), 32'd0);
    chk("t4_full_cnt", 32'(count_dbg), 32'd4);
    chk("t4_full_req", 32'(cdb_request), 32'd1);
    nxt();
    chk("t4_drop_flag", 32'(dut.u_chk.viol_cnt_r), 32'd1);
    drive(1'b0, 6'd0, 32'd0, 1'b1, 1'b0);
    chk("t4_pop10", 32'(out_tag), 32'd10);
    chk("t4_pop10_data", out_data, 32'hA000);
    chk("t4_pop10_prdy", 32'(push_ready), 32'd0);
    chk("t4_pop10_cnt", 32'(count_dbg), 32'd4);
    nxt();
    drive(1'b0, 6'd0, 32'd0, 1'b1, 1'b0);
    chk("t4_prdy_back", 32'(push_ready), 32'd1);
    chk("t4_pop11", 32'(out_tag), 32'd11);
    nxt();
    drive(1'b0, 6'd0, 32'd0, 1'b1, 1'b0);
    chk("t4_pop12", 32'(out_tag), 32'd12);
    nxt();
    drive(1'b0, 6'd0, 32'd0, 1'b1, 1'b0);
    chk("t4_pop13", 32'(out_tag), 32'd13);
    chk("t4_pop13_data", out_data, 32'hA003);
    chk("t4_last_req", 32'(cdb_request), 32'd0);
    nxt();
    drive(1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
    chk("t4_empty_cnt", 32'(count_dbg), 32'd0);
    chk("t4_empty_ov", 32'(out_valid), 32'd0);
    nxt();

    // Flush while granted with two entries queued.
    drive(1'b1, 6'd20, 32'h20, 1'b0, 1'b0);
    nxt();
    drive(1'b1, 6'd21, 32'h21, 1'b0, 1'b0);
    nxt();
    drive(1'b1, 6'd22, 32'h22, 1'b1, 1'b1);
    chk("t5_cnt_pre", 32'(count_dbg), 32'd2);
    chk("t5_flush_ov", 32'(out_valid), 32'd0);
    chk("t5_flush_tag", 32'(out_tag), 32'd0);
    chk("t5_flush_req", 32'(cdb_request), 32'd0);
    nxt();
    drive(1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
    chk("t5_after_cnt", 32'(count_dbg), 32'd0);
    chk("t5_after_req", 32'(cdb_request), 32'd0);
    nxt();
    drive(1'b0, 6'd0, 32'd0, 1'b1, 1'b0);
    chk("t5_spur_ov", 32'(out_valid), 32'd0);
    chk("t5_spur_data", out_data, 32'd0);
    nxt();
    chk("t5_spur_flag", 32'(dut.u_chk.viol_cnt_r), 32'd2);
    chk("t5_spur_cnt", 32'(count_dbg), 32'd0);

    // Push and pop in the same cycle keep occupancy and order.
    drive(1'b1, 6'd7, 32'h77, 1'b0, 1'b0);
    nxt();
    drive(1'b1, 6'd8, 32'h88, 1'b1, 1'b0);
    chk("t6_tag7", 32'(out_tag), 32'd7);
    chk("t6_data7", out_data, 32'h77);
    chk("t6_cnt", 32'(count_dbg), 32'd1);
    chk("t6_req", 32'(cdb_request), 32'd1);
    nxt();
    drive(1'b0, 6'd0, 32'd0, 1'b1, 1'b0);
    chk("t6_cnt_kept", 32'(count_dbg), 32'd1);
    chk("t6_tag8", 32'(out_tag), 32'd8);
    chk("t6_data8", out_data, 32'h88);
    nxt();

    // Reset and flush together empty a non-empty queue.
    drive(1'b1, 6'd30, 32'h30, 1'b0, 1'b0);
    nxt();
    reset = 1'b1;
    drive(1'b0, 6'd0, 32'd0, 1'b1, 1'b1);
    chk("t7_rstfl_ov", 32'(out_valid), 32'd0);
    chk("t7_rstfl_req", 32'(cdb_request), 32'd0);
    nxt();
    reset = 1'b0;
    drive(1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
    chk("t7_cnt", 32'(count_dbg), 32'd0);
    chk("t7_prdy", 32'(push_ready), 32'd1);
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
